gray_capture: RTL and testbench

GRAY_CAPTURE -- requirements
Module: gray_capture

---
 rtl/gray_capture.sv | 202 ++++++++++++++++++++
 tb/tb_gray_capture.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/gray_capture.sv
// gray_capture: synchronises a Gray-coded timer count and its terminal-count
// interrupt, decodes the count to binary, watches for illegal Gray steps and
// captures the decoded value on an interrupt edge or a software read request.
module gray_capture #(
  parameter int unsigned SIZE = 8
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic [SIZE-1:0] Gray_in,
  input  logic            Int_in,
  input  logic            Rd_req,
  input  logic            Ack,
  output logic [SIZE-1:0] Bin_out,
  output logic            Valid,
  output logic            Done,
  output logic            Err,
  output logic [3:0]      Err_cnt
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [SIZE-1:0] r_s1_gray;
  logic [SIZE-1:0] r_s2_gray;
  logic            r_s1_int;
  logic            r_s2_int;
  logic            r_int_d;
  logic [SIZE-1:0] r_prev;
  logic            r_primed;
  logic [SIZE-1:0] r_bin_dec;
  logic            r_pend;

  logic [SIZE-1:0] r_bin_out;
  logic            r_valid;
  logic            r_done;
  logic            r_err;
  logic [3:0]      r_err_cnt;

  logic [SIZE-1:0] w_bin;
  logic [SIZE-1:0] w_diff;
  logic            w_seen;
  logic            w_multi;
  logic            w_int_edge;
  logic            w_cap;
  logic            w_cap_done;
  logic            w_release;
  logic            w_pend_set;
  logic            w_pend_clr;

  assign Bin_out = r_bin_out;
  assign Valid   = r_valid;
  assign Done    = r_done;
  assign Err     = r_err;
  assign Err_cnt = r_err_cnt;

  // Two-stage synchronisers for the count bus and the interrupt level.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_s1_gray <= '0;
      r_s2_gray <= '0;
      r_s1_int  <= 1'b0;
      r_s2_int  <= 1'b0;
      r_int_d   <= 1'b0;
    end else begin
      r_s1_gray <= Gray_in;
      r_s2_gray <= r_s1_gray;
      r_s1_int  <= Int_in;
      r_s2_int  <= r_s1_int;
      r_int_d   <= r_s2_int;
    end
  end

  // Gray-to-binary decode: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    w_bin = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      w_bin[i] = ^(r_s2_gray >> i);
    end
  end

  // Register the decoded count so captures see a stable value.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_bin_dec <= '0;
    end else begin
      r_bin_dec <= w_bin;
    end
  end

  // Flag a step when more than one bit changed between consecutive samples.
  always_comb begin
    w_diff  = r_s2_gray ^ r_prev;
    w_seen  = 1'b0;
    w_multi = 1'b0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      if (w_diff[i]) begin
        if (w_seen) begin
          w_multi = 1'b1;
        end
        w_seen = 1'b1;
      end
    end
  end

  // Previous-sample tracking and the sticky / saturating error record.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_prev    <= '0;
      r_primed  <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_prev   <= r_s2_gray;
      r_primed <= 1'b1;
      if (r_primed && w_multi) begin
        r_err <= 1'b1;
        if (r_err_cnt != '1) begin
          r_err_cnt <= r_err_cnt + 4'd1;
        end
      end
    end
  end

  assign w_int_edge = r_s2_int & ~r_int_d;

  // Capture FSM state register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture FSM next-state and control decode; interrupt (live or pending) beats a read.
  always_comb begin
    w_state_nxt = r_state;
    w_cap       = 1'b0;
    w_cap_done  = 1'b0;
    w_release   = 1'b0;
    w_pend_set  = 1'b0;
    w_pend_clr  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_int_edge || r_pend) begin
          w_cap       = 1'b1;
          w_cap_done  = 1'b1;
          w_pend_clr  = 1'b1;
          w_state_nxt = HOLD;
        end else if (Rd_req) begin
          w_cap       = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (w_int_edge) begin
          w_pend_set = 1'b1;
        end
        if (Ack) begin
          w_release   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Pending interrupt that arrived while a capture was being held.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_pend <= 1'b0;
    end else if (w_pend_set) begin
      r_pend <= 1'b1;
    end else if (w_pend_clr) begin
      r_pend <= 1'b0;
    end
  end

  // Output capture registers; Bin_out only moves on a capture.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_bin_out <= '0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
    end else if (w_cap) begin
      r_bin_out <= r_bin_dec;
      r_valid   <= 1'b1;
      r_done    <= w_cap_done;
    end else if (w_release) begin
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gray_capture.sv
// Bench for gray_capture: directed scenarios followed by a random phase, all
// checked every cycle against a history-based reference model.
module tb_gray_capture;

  localparam int unsigned SIZE = 8;

  logic            Clk = 1'b0;
  logic            Rst;
  logic [SIZE-1:0] Gray_in;
  logic            Int_in;
  logic            Rd_req;
  logic            Ack;
  logic [SIZE-1:0] Bin_out;
  logic            Valid;
  logic            Done;
  logic            Err;
  logic [3:0]      Err_cnt;

  gray_capture #(.SIZE(SIZE)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .Gray_in (Gray_in),
    .Int_in  (Int_in),
    .Rd_req  (Rd_req),
    .Ack     (Ack),
    .Bin_out (Bin_out),
    .Valid   (Valid),
    .Done    (Done),
    .Err     (Err),
    .Err_cnt (Err_cnt)
  );

  always #5 Clk = ~Clk;

  int n_asrt = 0;
  int n_fail = 0;

  // Input history, indexed by the clock edge at which each value was sampled.
  logic [7:0] gh [0:4095];
  logic       ih [0:4095];
  int         n;

  logic [7:0] m_bin;
  logic       m_valid, m_done, m_err, m_hold, m_pend;
  int         m_cnt;

  logic [7:0] cur_g;
  logic       cur_i;

  function automatic logic [7:0] g2b(input logic [7:0] g);
    logic [7:0] b;
    b = g;
    for (int k = 1; k < 8; k++) b = b ^ (g >> k);
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asrt++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: synchronised count seen after edge e is gh[e-1]; decoded count
  // and the step-check "previous" value lag one further edge.
  task automatic model_edge(input logic rst, input logic [7:0] g, input logic i,
                            input logic rd, input logic ak);
    logic       ie;
    logic [7:0] dec;
    gh[n] = g;
    ih[n] = i;
    if (rst) begin
      gh[n] = '0; gh[n-1] = '0; gh[n-2] = '0;
      ih[n] = 1'b0; ih[n-1] = 1'b0; ih[n-2] = 1'b0;
      m_bin = '0; m_valid = 1'b0; m_done = 1'b0; m_err = 1'b0; m_cnt = 0;
      m_hold = 1'b0; m_pend = 1'b0;
    end else begin
      if ($countones(gh[n-2] ^ gh[n-3]) > 1) begin
        m_err = 1'b1;
        if (m_cnt < 15) m_cnt++;
      end
      ie  = ih[n-2] && !ih[n-3];
      dec = g2b(gh[n-3]);
      if (!m_hold) begin
        if (ie || m_pend) begin
          m_bin = dec; m_valid = 1'b1; m_done = 1'b1; m_pend = 1'b0; m_hold = 1'b1;
        end else if (rd) begin
          m_bin = dec; m_valid = 1'b1; m_done = 1'b0; m_hold = 1'b1;
        end
      end else begin
        if (ie) m_pend = 1'b1;
        if (ak) begin
          m_valid = 1'b0; m_done = 1'b0; m_hold = 1'b0;
        end
      end
    end
    n++;
  endtask

  task automatic tick(input logic rst, input logic rd, input logic ak);
    Rst = rst; Gray_in = cur_g; Int_in = cur_i; Rd_req = rd; Ack = ak;
    @(posedge Clk);
    model_edge(rst, cur_g, cur_i, rd, ak);
    #1;
    chk("bin_out", 32'(Bin_out), 32'(m_bin));
    chk("valid",   32'(Valid),   32'(m_valid));
    chk("done",    32'(Done),    32'(m_done));
    chk("err",     32'(Err),     32'(m_err));
    chk("err_cnt", 32'(Err_cnt), 32'(m_cnt));
  endtask

  logic [7:0] pat [0:4];

  initial begin
    pat[0] = 8'h00; pat[1] = 8'h03; pat[2] = 8'h0C; pat[3] = 8'h30; pat[4] = 8'hC0;
    for (int k = 0; k < 3; k++) begin gh[k] = '0; ih[k] = 1'b0; end
    n = 3;
    cur_g = '0; cur_i = 1'b0;
    m_bin = '0; m_valid = 1'b0; m_done = 1'b0; m_err = 1'b0; m_cnt = 0;
    m_hold = 1'b0; m_pend = 1'b0;

    // Reset
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    chk("rst_valid", 32'(Valid), 32'd0);
    chk("rst_bin", 32'(Bin_out), 32'd0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);

    // Read capture of 0x07 reached by legal steps
    cur_g = 8'h01; tick(1'b0, 1'b0, 1'b0);
    cur_g = 8'h03; tick(1'b0, 1'b0, 1'b0);
    cur_g = 8'h07;
    repeat (4) tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    chk("rd_bin", 32'(Bin_out), 32'h05);
    chk("rd_valid", 32'(Valid), 32'd1);
    chk("rd_done", 32'(Done), 32'd0);
    tick(1'b0, 1'b0, 1'b1);
    chk("ack_valid", 32'(Valid), 32'd0);

    // Legal Gray walk to 0xAC, then interrupt capture
    for (int b = 6; b <= 200; b++) begin
      cur_g = 8'(b) ^ (8'(b) >> 1);
      tick(1'b0, 1'b0, 1'b0);
    end
    cur_i = 1'b1;
    repeat (5) tick(1'b0, 1'b0, 1'b0);
    chk("int_bin", 32'(Bin_out), 32'hC8);
    chk("int_done", 32'(Done), 32'd1);
    chk("int_err", 32'(Err), 32'd0);
    tick(1'b0, 1'b0, 1'b1);
    cur_i = 1'b0;
    repeat (3) tick(1'b0, 1'b0, 1'b0);

    // Interrupt edge and read in the same cycle
    cur_i = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    chk("coinc_done", 32'(Done), 32'd1);
    tick(1'b0, 1'b0, 1'b1);
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    chk("coinc_no_second", 32'(Valid), 32'd0);

    // Interrupt arriving while a read capture is held
    cur_i = 1'b0;
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    cur_g = cur_g ^ 8'h01;
    cur_i = 1'b1;
    repeat (5) tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    chk("pend_gap", 32'(Valid), 32'd0);
    tick(1'b0, 1'b0, 1'b0);
    chk("pend_valid", 32'(Valid), 32'd1);
    chk("pend_done", 32'(Done), 32'd1);
    chk("pend_bin", 32'(Bin_out), 32'(g2b(cur_g)));
    tick(1'b0, 1'b0, 1'b1);
    cur_i = 1'b0;
    repeat (2) tick(1'b0, 1'b0, 1'b0);

    // Twenty-plus illegal steps saturate the error counter
    for (int k = 0; k < 21; k++) begin
      cur_g = pat[k % 5];
      tick(1'b0, 1'b0, 1'b0);
    end
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    chk("sat_err", 32'(Err), 32'd1);
    chk("sat_cnt", 32'(Err_cnt), 32'd15);

    // Reset in HOLD with Err set, then 0x80 right after reset
    tick(1'b0, 1'b1, 1'b0);
    cur_g = 8'h80;
    tick(1'b1, 1'b0, 1'b0);
    chk("rst_hold_valid", 32'(Valid), 32'd0);
    chk("rst_hold_err", 32'(Err), 32'd0);
    chk("rst_hold_cnt", 32'(Err_cnt), 32'd0);
    repeat (4) tick(1'b0, 1'b0, 1'b0);
    chk("post_rst_err", 32'(Err), 32'd0);

    // Random phase
    for (int c = 0; c < 400; c++) begin
      int unsigned r;
      r = $urandom_range(0, 15);
      if (r == 0) cur_g = 8'($urandom);
      else if (r < 8) cur_g = cur_g ^ (8'd1 << $urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) cur_i = ~cur_i;
      tick(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
